cvxif_mad_scheduler: RTL and testbench

Multi-entry issue scheduler between the CV-X-IF issue/commit/result channels and the shared multi-cycle `mad` unit. It replaces the single-entry hold-and-wait scheme. Up to `NrEntries` offloaded instructions are buffered, and the `mad` unit is started speculatively in program order, before commit. Only committed results are returned to the core, in order; killed instructions are dropped.

---
 rtl/cvxif_mad_scheduler.sv | 156 +++++++++++++++
 tb/tb_cvxif_mad_scheduler.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvxif_mad_scheduler.sv
// Multi-entry CV-X-IF offload scheduler: buffers issued ops, runs them on the shared
// mad unit speculatively in program order, and returns only committed results in order.
module cvxif_mad_scheduler #(
  parameter int unsigned NrEntries = 4,
  parameter int unsigned IdWidth   = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       issue_valid_i,
  output logic                       issue_ready_o,
  input  logic [IdWidth-1:0]         issue_id_i,
  input  logic [4:0]                 issue_rd_i,
  input  logic                       issue_we_i,
  input  logic [31:0]                issue_rs1_i,
  input  logic [31:0]                issue_rs2_i,
  input  logic                       commit_valid_i,
  input  logic [IdWidth-1:0]         commit_id_i,
  input  logic                       commit_kill_i,
  output logic                       mad_start_o,
  output logic [31:0]                mad_op_a_o,
  output logic [31:0]                mad_op_b_o,
  input  logic                       mad_done_i,
  input  logic [31:0]                mad_result_i,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output logic [IdWidth-1:0]         result_id_o,
  output logic [4:0]                 result_rd_o,
  output logic [31:0]                result_data_o,
  output logic                       result_we_o,
  output logic [$clog2(NrEntries):0] occupancy_o
);
  localparam int unsigned PW = $clog2(NrEntries);
  localparam logic [PW:0] PtrOne = {{PW{1'b0}}, 1'b1};

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [4:0]         rd;
    logic               we;
    logic [31:0]        rs1;
    logic [31:0]        rs2;
    logic [31:0]        data;
  } entry_t;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  entry_t               r_ent [NrEntries];
  logic [NrEntries-1:0] r_vld, r_cmt, r_kill, r_done;
  // Pointers carry an extra wrap bit so a full buffer is distinct from an empty one.
  logic [PW:0]          r_tail, r_head, r_exec;
  state_e               r_state, w_state_nxt;

  logic [PW-1:0] w_tidx, w_hidx, w_eidx;
  logic [PW:0]   w_occ;
  logic          w_push, w_pop, w_free_kill, w_head_busy, w_rvalid;
  logic          w_start, w_exec_adv, w_done_wr;

  assign w_tidx = r_tail[PW-1:0];
  assign w_hidx = r_head[PW-1:0];
  assign w_eidx = r_exec[PW-1:0];

  assign w_occ         = r_tail - r_head;
  assign issue_ready_o = ~w_occ[PW];
  assign w_push        = issue_valid_i & issue_ready_o;

  // A killed head still owned by the running mad op must wait for its done.
  assign w_head_busy = (r_state == S_RUN) && (r_head == r_exec);
  assign w_free_kill = r_vld[w_hidx] & r_kill[w_hidx] & (r_done[w_hidx] | ~w_head_busy);
  assign w_rvalid    = r_vld[w_hidx] & r_done[w_hidx] & r_cmt[w_hidx] & ~r_kill[w_hidx];
  assign w_pop       = w_free_kill | (w_rvalid & result_ready_i);

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_exec_adv  = 1'b0;
    w_done_wr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_exec != r_tail) && r_vld[w_eidx]) begin
          if (r_kill[w_eidx]) begin
            w_exec_adv = 1'b1;
          end else begin
            w_start     = 1'b1;
            w_state_nxt = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (mad_done_i) begin
          w_done_wr   = 1'b1;
          w_exec_adv  = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_vld  <= '0;
      r_cmt  <= '0;
      r_kill <= '0;
      r_done <= '0;
      r_tail <= '0;
      r_head <= '0;
      r_exec <= '0;
    end else begin
      for (int i = 0; i < NrEntries; i++) begin
        if (commit_valid_i && r_vld[i] && (r_ent[i].id == commit_id_i)) begin
          if (commit_kill_i) r_kill[i] <= 1'b1;
          else               r_cmt[i]  <= 1'b1;
        end
      end
      if (w_done_wr) r_done[w_eidx] <= 1'b1;
      if (w_exec_adv) r_exec <= r_exec + PtrOne;
      if (w_pop) begin
        r_vld[w_hidx] <= 1'b0;
        r_head        <= r_head + PtrOne;
      end
      // A commit naming the id being pushed lands on the new entry.
      if (w_push) begin
        r_vld[w_tidx]  <= 1'b1;
        r_cmt[w_tidx]  <= commit_valid_i && !commit_kill_i && (commit_id_i == issue_id_i);
        r_kill[w_tidx] <= commit_valid_i && commit_kill_i && (commit_id_i == issue_id_i);
        r_done[w_tidx] <= 1'b0;
        r_tail         <= r_tail + PtrOne;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_ent[w_tidx].id  <= issue_id_i;
      r_ent[w_tidx].rd  <= issue_rd_i;
      r_ent[w_tidx].we  <= issue_we_i;
      r_ent[w_tidx].rs1 <= issue_rs1_i;
      r_ent[w_tidx].rs2 <= issue_rs2_i;
    end
    if (w_done_wr) r_ent[w_eidx].data <= mad_result_i;
  end

  assign mad_start_o    = w_start;
  assign mad_op_a_o     = w_start ? r_ent[w_eidx].rs1 : '0;
  assign mad_op_b_o     = w_start ? r_ent[w_eidx].rs2 : '0;
  assign result_valid_o = w_rvalid;
  assign result_id_o    = w_rvalid ? r_ent[w_hidx].id : '0;
  assign result_rd_o    = w_rvalid ? r_ent[w_hidx].rd : '0;
  assign result_data_o  = w_rvalid ? r_ent[w_hidx].data : '0;
  assign result_we_o    = w_rvalid & r_ent[w_hidx].we;
  assign occupancy_o    = w_occ;
endmodule

// File: tb/tb_cvxif_mad_scheduler.sv
// Bench for cvxif_mad_scheduler: 3-cycle mad model, result scoreboard, vector table
// for single ops and hand-written sequences for full/kill/backpressure/reset cases.
module tb_cvxif_mad_scheduler;
  localparam int NE  = 4;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst_ni;
  logic           issue_valid_i, issue_ready_o;
  logic [IDW-1:0] issue_id_i;
  logic [4:0]     issue_rd_i;
  logic           issue_we_i;
  logic [31:0]    issue_rs1_i, issue_rs2_i;
  logic           commit_valid_i, commit_kill_i;
  logic [IDW-1:0] commit_id_i;
  logic           mad_start_o, mad_done_i;
  logic [31:0]    mad_op_a_o, mad_op_b_o, mad_result_i;
  logic           result_valid_o, result_ready_i, result_we_o;
  logic [IDW-1:0] result_id_o;
  logic [4:0]     result_rd_o;
  logic [31:0]    result_data_o;
  logic [$clog2(NE):0] occupancy_o;

  always #5 clk = ~clk;

  cvxif_mad_scheduler #(.NrEntries(NE), .IdWidth(IDW)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o), .issue_id_i(issue_id_i),
    .issue_rd_i(issue_rd_i), .issue_we_i(issue_we_i), .issue_rs1_i(issue_rs1_i),
    .issue_rs2_i(issue_rs2_i), .commit_valid_i(commit_valid_i), .commit_id_i(commit_id_i),
    .commit_kill_i(commit_kill_i), .mad_start_o(mad_start_o), .mad_op_a_o(mad_op_a_o),
    .mad_op_b_o(mad_op_b_o), .mad_done_i(mad_done_i), .mad_result_i(mad_result_i),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i), .result_id_o(result_id_o),
    .result_rd_o(result_rd_o), .result_data_o(result_data_o), .result_we_o(result_we_o),
    .occupancy_o(occupancy_o)
  );

  typedef struct { logic [IDW-1:0] id; logic [4:0] rd; logic we; logic [31:0] data; } exp_t;
  typedef struct {
    logic [IDW-1:0] id; logic [4:0] rd; logic we; logic [31:0] rs1; logic [31:0] rs2; logic [31:0] res;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs [4];
  logic [31:0] starts[$];
  int          errs = 0, checks = 0, cyc = 0, mad_due = -1;
  logic [31:0] mad_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Evaluate the current cycle, cross the clock edge, then set default inputs for the next.
  task automatic tick();
    exp_t e;
    if (result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL unexpected_result: got id %0d data %0h required none", result_id_o, result_data_o);
      end else begin
        e = sb.pop_front();
        chk("sb_id", result_id_o, e.id);
        chk("sb_data", result_data_o, e.data);
        chk("sb_rd", result_rd_o, e.rd);
        chk("sb_we", result_we_o, e.we);
      end
    end
    if (mad_start_o) begin
      mad_due = cyc + 3;
      mad_res = mad_op_a_o * mad_op_b_o;
      starts.push_back(mad_op_a_o);
    end
    @(posedge clk); #1;
    cyc++;
    issue_valid_i  = 1'b0;
    commit_valid_i = 1'b0;
    commit_kill_i  = 1'b0;
    mad_done_i     = (cyc == mad_due);
    mad_result_i   = mad_done_i ? mad_res : 32'h0;
  endtask

  task automatic do_issue(input logic [IDW-1:0] id, input logic [4:0] rd, input logic we,
                          input logic [31:0] a, input logic [31:0] b);
    issue_valid_i = 1'b1; issue_id_i = id; issue_rd_i = rd; issue_we_i = we;
    issue_rs1_i = a; issue_rs2_i = b;
  endtask

  task automatic do_commit(input logic [IDW-1:0] id, input logic kill);
    commit_valid_i = 1'b1; commit_id_i = id; commit_kill_i = kill;
  endtask

  task automatic expect_res(input logic [IDW-1:0] id, input logic [4:0] rd, input logic we,
                            input logic [31:0] data);
    exp_t e;
    e.id = id; e.rd = rd; e.we = we; e.data = data;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || occupancy_o != 0) && n < 60) begin tick(); n++; end
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_occ", occupancy_o, 0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ready"}, issue_ready_o, 1);
    chk({tag, "_start"}, mad_start_o, 0);
    chk({tag, "_rvalid"}, result_valid_o, 0);
    chk({tag, "_occ"}, occupancy_o, 0);
    chk({tag, "_rdata"}, result_data_o, 0);
    chk({tag, "_rid"}, result_id_o, 0);
    chk({tag, "_rwe"}, result_we_o, 0);
    chk({tag, "_opa"}, mad_op_a_o, 0);
  endtask

  task automatic run_vec(input vec_t v);
    do_issue(v.id, v.rd, v.we, v.rs1, v.rs2);
    chk("vec_ready", issue_ready_o, 1);
    tick();
    chk("vec_start_n1", mad_start_o, 1);
    chk("vec_opa", mad_op_a_o, v.rs1);
    chk("vec_opb", mad_op_b_o, v.rs2);
    chk("vec_occ", occupancy_o, 1);
    tick();
    do_commit(v.id, 1'b0);
    expect_res(v.id, v.rd, v.we, v.res);
    chk("vec_start_n2", mad_start_o, 0);
    tick(); tick();
    chk("vec_rvalid_n4", result_valid_o, 0);
    tick();
    chk("vec_rvalid_n5", result_valid_o, 1);
    chk("vec_rdata", result_data_o, v.res);
    chk("vec_rid", result_id_o, v.id);
    chk("vec_rwe", result_we_o, v.we);
    tick();
    chk("vec_rvalid_n6", result_valid_o, 0);
    chk("vec_occ_end", occupancy_o, 0);
  endtask

  initial begin
    int n;
    int bad;
    rst_ni = 1'b0; issue_valid_i = 1'b0; issue_id_i = '0; issue_rd_i = '0; issue_we_i = 1'b0;
    issue_rs1_i = '0; issue_rs2_i = '0; commit_valid_i = 1'b0; commit_id_i = '0;
    commit_kill_i = 1'b0; mad_done_i = 1'b0; mad_result_i = '0; result_ready_i = 1'b1;

    vecs[0] = '{id: 3'd1, rd: 5'd5,  we: 1'b1, rs1: 32'd6,          rs2: 32'd7,      res: 32'd42};
    vecs[1] = '{id: 3'd3, rd: 5'd31, we: 1'b0, rs1: 32'd0,          rs2: 32'd123,    res: 32'd0};
    vecs[2] = '{id: 3'd7, rd: 5'd0,  we: 1'b1, rs1: 32'hFFFF_FFFF,  rs2: 32'd2,      res: 32'hFFFF_FFFE};
    vecs[3] = '{id: 3'd0, rd: 5'd10, we: 1'b1, rs1: 32'h0001_0000,  rs2: 32'h0001_0000, res: 32'h0};

    tick(); tick();
    chk_reset_outs("reset");
    rst_ni = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Full buffer: four back-to-back issues, a fifth is refused.
    for (int k = 0; k < 4; k++) begin
      do_issue(k[IDW-1:0], k[4:0], 1'b1, 32'(k + 2), 32'd10);
      chk("full_ready_pre", issue_ready_o, 1);
      tick();
    end
    chk("full_ready_0", issue_ready_o, 0);
    chk("full_occ4", occupancy_o, 4);
    do_issue(3'd5, 5'd5, 1'b1, 32'd99, 32'd99);
    tick();
    chk("full_refused_occ", occupancy_o, 4);
    chk("full_ready_still0", issue_ready_o, 0);
    do_commit(3'd0, 1'b0);
    expect_res(3'd0, 5'd0, 1'b1, 32'd20);
    tick();
    chk("full_pop_valid", result_valid_o, 1);
    chk("full_ready_on_pop", issue_ready_o, 0);
    tick();
    chk("full_ready_after_pop", issue_ready_o, 1);
    chk("full_occ3", occupancy_o, 3);
    for (int k = 1; k < 4; k++) begin
      do_commit(k[IDW-1:0], 1'b0);
      expect_res(k[IDW-1:0], k[4:0], 1'b1, 32'((k + 2) * 10));
      tick();
    end
    drain();

    // Kill while running: id 2 never returns, id 3 starts after its done.
    do_issue(3'd2, 5'd2, 1'b1, 32'd3, 32'd3);
    tick();
    chk("kr_start2", mad_start_o, 1);
    do_issue(3'd3, 5'd3, 1'b1, 32'd5, 32'd5);
    tick();
    do_commit(3'd2, 1'b1);
    tick(); tick();
    chk("kr_occ_at_done", occupancy_o, 2);
    tick();
    chk("kr_next_start", mad_start_o, 1);
    chk("kr_next_opa", mad_op_a_o, 5);
    chk("kr_occ_held", occupancy_o, 2);
    tick();
    chk("kr_occ_freed", occupancy_o, 1);
    do_commit(3'd3, 1'b0);
    expect_res(3'd3, 5'd3, 1'b1, 32'd25);
    drain();

    // Kill while queued: id 4 is skipped and never reaches mad.
    starts.delete();
    do_issue(3'd6, 5'd6, 1'b1, 32'd2, 32'd3);
    tick();
    do_issue(3'd4, 5'd4, 1'b1, 32'h44, 32'd1);
    tick();
    do_issue(3'd5, 5'd5, 1'b0, 32'd9, 32'd9);
    do_commit(3'd4, 1'b1);
    tick();
    do_commit(3'd6, 1'b0);
    expect_res(3'd6, 5'd6, 1'b1, 32'd6);
    tick();
    do_commit(3'd5, 1'b0);
    expect_res(3'd5, 5'd5, 1'b0, 32'd81);
    drain();
    bad = 0;
    foreach (starts[j]) if (starts[j] == 32'h44) bad++;
    chk("kq_id4_never_started", bad, 0);
    chk("kq_start_count", starts.size(), 2);

    // Backpressure, with commits landing in the same cycle as their push.
    result_ready_i = 1'b0;
    do_issue(3'd0, 5'd8, 1'b1, 32'd11, 32'd1);
    do_commit(3'd0, 1'b0);
    expect_res(3'd0, 5'd8, 1'b1, 32'd11);
    tick();
    do_issue(3'd1, 5'd9, 1'b1, 32'd12, 32'd1);
    do_commit(3'd1, 1'b0);
    expect_res(3'd1, 5'd9, 1'b1, 32'd12);
    tick();
    n = 0;
    while (!result_valid_o && n < 20) begin tick(); n++; end
    chk("bp_first_valid_in_time", result_valid_o, 1);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", result_valid_o, 1);
      chk("bp_hold_id", result_id_o, 0);
      chk("bp_hold_data", result_data_o, 11);
      chk("bp_hold_rd", result_rd_o, 8);
      tick();
    end
    result_ready_i = 1'b1;
    chk("bp_pop_id", result_id_o, 0);
    tick();
    chk("bp_second_valid", result_valid_o, 1);
    chk("bp_second_id", result_id_o, 1);
    chk("bp_second_data", result_data_o, 12);
    drain();

    // Reset during RUN: outputs clear and the late done is ignored.
    do_issue(3'd1, 5'd3, 1'b1, 32'd4, 32'd4);
    tick();
    chk("rr_start", mad_start_o, 1);
    tick();
    rst_ni = 1'b0;
    tick();
    chk_reset_outs("rr");
    rst_ni = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rr_no_start", mad_start_o, 0);
      chk("rr_no_result", result_valid_o, 0);
      chk("rr_occ0", occupancy_o, 0);
    end
    run_vec(vecs[0]);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish");
    $fatal(1);
  end
endmodule
